wb_queue: RTL
=============

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001: Parameter DEPTH, default 4, number of pending load-writeback entries (power of two, >=2).
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: reset  input  1  asynchronous, active-low; low clears all state immediately, independent of clk.
REQ-004: alu_valid  input  1  ALU-result writeback request, always accepted, no ready.
REQ-005: alu_reg  input  5  ALU destination register.
REQ-006: alu_data  input  64  ALU result.
REQ-007: mem_valid  input  1  load-result writeback request.
REQ-008: mem_ready  output  1  queue can accept a load result this cycle.
REQ-009: mem_reg  input  5  load destination register.
REQ-010: mem_data  input  64  load data.
REQ-011: RegWrite  output  1  registered write enable to the register file.
REQ-012: WriteRegister  output  5  registered register-file write address.
REQ-013: WriteData  output  64  registered register-file write data.
REQ-014: pend_query1, pend_query2  input  5 each  register numbers being read by decode.
REQ-015: pend_hit1, pend_hit2  output  1 each  queried register has a write not yet committed to the register file.
REQ-016: fifo_count  output  $clog2(DEPTH)+1  number of occupied queue slots.

Function
REQ-017: Load handshake: transfer occurs on a rising edge where mem_valid && mem_ready; mem_ready = (fifo_count < DEPTH), combinational from count only; no push when full, even if a pop happens that cycle.
REQ-018: Accepted load writes a FIFO slot {reg, data, live=1} at the tail; tail and head pointers wrap modulo DEPTH.
REQ-019: Output stage loads every edge, priority: (1) alu_valid -> {1, alu_reg, alu_data}; (2) else FIFO non-empty -> pop head, RegWrite = head.live, WriteRegister/WriteData = head fields; (3) else RegWrite=0, WriteRegister/WriteData hold.
REQ-020: Latency: ALU request in cycle N drives outputs after edge N+1; load accepted at edge N appears on outputs no earlier than edge N+1 following the push edge (minimum 2 cycles from mem_valid sample cycle to RegWrite).
REQ-021: Simultaneous push and pop: fifo_count unchanged; push-only +1; pop-only -1.
REQ-022: Register 31 (zero register): ALU requests with alu_reg=31 produce RegWrite=0 (output stage still loads and blocks a FIFO pop that cycle); loads with mem_reg=31 are accepted and queued with live=0.
REQ-023: Write-after-write ordering: an ALU request is always the youngest write; when alu_valid, every valid FIFO entry (including one pushed the same edge) with reg == alu_reg gets live=0.
REQ-024: Killed entries (live=0) keep their slot, pop in order, and produce one cycle of RegWrite=0.
REQ-025: pend_hitK (combinational) = 1 iff pend_queryK != 31 and (a valid FIFO entry with live=1 has reg == pend_queryK, or RegWrite && WriteRegister == pend_queryK).
REQ-026: fifo_count never exceeds DEPTH and never underflows; pop occurs only when non-empty.

Reset
REQ-027: While reset low: RegWrite=0, WriteRegister=0, WriteData=0, fifo_count=0, pointers=0, all live=0, so mem_ready=1 and pend_hit1/2=0.
REQ-028: Reset asserted mid-operation discards all queued entries; no write for a discarded entry appears after reset release.
REQ-029: First edge after reset release behaves per REQ-019 with an empty FIFO.

Verification
REQ-030: Single ALU: alu_valid=1, alu_reg=5, alu_data=0xAA for one cycle -> next cycle RegWrite=1, WriteRegister=5, WriteData=0xAA, then RegWrite=0.
REQ-031: Fill/backpressure: 4 loads to regs 1..4 with alu_valid=1 (regs 10..13) each cycle -> fifo_count=4, mem_ready=0, 5th load held; drop alu_valid -> loads commit in order 1,2,3,4, one per cycle.
REQ-032: WAW kill: load reg 7 data 0x1 queued, then ALU reg 7 data 0x2 while queue occupied -> RegWrite for reg 7 with 0x2 only; later pop gives a RegWrite=0 cycle; pend_hit for 7 drops after ALU write commits.
REQ-033: Zero register: ALU reg 31 and load reg 31 -> never RegWrite=1 with WriteRegister=31; pend_query=31 -> pend_hit=0.
REQ-034: Pending query: load reg 9 queued -> pend_query1=9 gives pend_hit1=1 until the edge after RegWrite=1/WriteRegister=9, then 0.
REQ-035: Reset mid-stream: 3 queued loads, drive reset low between edges -> outputs and fifo_count 0 immediately, mem_ready=1; after release no queued write emerges.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: writeback merge of ALU results and a small in-order load FIFO with WAW kill and pending-write lookup
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_reg,
  input  logic [63:0]              alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_reg,
  input  logic [63:0]              mem_data,
  output logic                     RegWrite,
  output logic [4:0]               WriteRegister,
  output logic [63:0]              WriteData,
  input  logic [4:0]               pend_query1,
  input  logic [4:0]               pend_query2,
  output logic                     pend_hit1,
  output logic                     pend_hit2,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [4:0]       regQ  [DEPTH];
  logic [63:0]      dataQ [DEPTH];
  logic [DEPTH-1:0] liveQ, validQ;
  logic [AW-1:0]    headPtr, tailPtr;
  logic             doPush, doPop, hit1, hit2;
  assign mem_ready = fifo_count < CW'(DEPTH);
  assign doPush = mem_valid && mem_ready;
  // ALU results own the output stage; the FIFO drains only in ALU-idle cycles
  assign doPop = !alu_valid && fifo_count != '0;
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1 = hit1 | (validQ[i] && liveQ[i] && regQ[i] == pend_query1);
      hit2 = hit2 | (validQ[i] && liveQ[i] && regQ[i] == pend_query2);
    end
    pend_hit1 = pend_query1 != 5'd31 && (hit1 || (RegWrite && WriteRegister == pend_query1));
    pend_hit2 = pend_query2 != 5'd31 && (hit2 || (RegWrite && WriteRegister == pend_query2));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      fifo_count    <= '0;
      headPtr       <= '0;
      tailPtr       <= '0;
      liveQ         <= '0;
      validQ        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regQ[i]  <= '0;
        dataQ[i] <= '0;
      end
    end else begin
      if (alu_valid) begin
        RegWrite      <= alu_reg != 5'd31;
        WriteRegister <= alu_reg;
        WriteData     <= alu_data;
      end else if (doPop) begin
        RegWrite      <= liveQ[headPtr];
        WriteRegister <= regQ[headPtr];
        WriteData     <= dataQ[headPtr];
      end else begin
        RegWrite <= 1'b0;
      end
      // An ALU write is always youngest, so older queued writes to the same register die
      for (int i = 0; i < DEPTH; i++)
        if (alu_valid && validQ[i] && regQ[i] == alu_reg) liveQ[i] <= 1'b0;
      if (doPop) begin
        validQ[headPtr] <= 1'b0;
        headPtr         <= headPtr + AW'(1);
      end
      if (doPush) begin
        regQ[tailPtr]   <= mem_reg;
        dataQ[tailPtr]  <= mem_data;
        liveQ[tailPtr]  <= mem_reg != 5'd31 && !(alu_valid && alu_reg == mem_reg);
        validQ[tailPtr] <= 1'b1;
        tailPtr         <= tailPtr + AW'(1);
      end
      fifo_count <= fifo_count + CW'(doPush) - CW'(doPop);
    end
  end
endmodule
